// File: rtl/and_result_packer.sv
// Packs PACK consecutive DATA_W-bit gate results into one word behind a valid/ready output.
// Optional `AND_PACK_PARITY_EN adds a registered even-parity bit over out_data.
module and_result_packer #(
    parameter int unsigned DATA_W = 4,
    parameter int unsigned PACK   = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [DATA_W-1:0]          in_data,
    output logic                       in_ready,
    input  logic                       flush,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W*PACK-1:0]     out_data,
`ifdef AND_PACK_PARITY_EN
    output logic                       out_parity,
`endif
    output logic [$clog2(PACK+1)-1:0]  out_cnt
);

    localparam int unsigned CNT_W  = $clog2(PACK + 1);
    localparam int unsigned LC_W   = $clog2(PACK);
    localparam int unsigned WORD_W = DATA_W * PACK;

    logic [PACK-1:0][DATA_W-1:0] lanes;
    logic [LC_W-1:0]             lane_cnt;

    logic                        slot_free_c;
    logic                        last_lane_c;
    logic                        accept_c;
    logic                        close_c;
    logic [PACK-1:0][DATA_W-1:0] word_c;
    logic [CNT_W-1:0]            word_cnt_c;

    // Handshake and close decisions, all from registered state plus current inputs.
    always_comb begin
        slot_free_c = !out_valid || out_ready;
        last_lane_c = (lane_cnt == LC_W'(PACK - 1));
        in_ready    = !(last_lane_c && !slot_free_c)
                   && !(flush && (lane_cnt != '0) && !slot_free_c);
        accept_c    = in_valid && in_ready;
        close_c     = (accept_c && last_lane_c)
                   || (flush && ((lane_cnt != '0) || accept_c) && slot_free_c);
    end

    // Word as it would close this cycle; lanes above lane_cnt are already zero.
    always_comb begin
        word_c     = lanes;
        word_cnt_c = CNT_W'(lane_cnt) + CNT_W'(accept_c);
        if (accept_c) begin
            word_c[lane_cnt] = in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lanes     <= '0;
            lane_cnt  <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_cnt   <= '0;
`ifdef AND_PACK_PARITY_EN
            out_parity <= 1'b0;
`endif
        end else if (close_c) begin
            out_data  <= WORD_W'(word_c);
            out_cnt   <= word_cnt_c;
            out_valid <= 1'b1;
            lane_cnt  <= '0;
            lanes     <= '0;
`ifdef AND_PACK_PARITY_EN
            out_parity <= ^word_c;
`endif
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (accept_c) begin
                lanes[lane_cnt] <= in_data;
                lane_cnt        <= lane_cnt + LC_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_and_result_packer.sv
// Directed self-checking bench for and_result_packer with PACK=4, DATA_W=4.
// Build with +define+AND_PACK_PARITY_EN to also check the parity output.
module tb_and_result_packer;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [3:0]  in_data;
    logic        in_ready;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [2:0]  out_cnt;
`ifdef AND_PACK_PARITY_EN
    logic        out_parity;
`endif

    int total = 0;
    int bad   = 0;

    and_result_packer #(.DATA_W(4), .PACK(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
`ifdef AND_PACK_PARITY_EN
        .out_parity(out_parity),
`endif
        .out_cnt   (out_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge; inputs are driven and outputs sampled 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; in_data = 4'hF; flush = 1'b0; out_ready = 1'b1;
        step();
        step();
        total++;
        if (out_valid !== 1'b0) begin
            bad++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid);
        end
        total++;
        if (out_cnt !== 3'd0) begin
            bad++; $display("FAIL reset_out_cnt got=%0d exp=0", out_cnt);
        end
        total++;
        if (in_ready !== 1'b1) begin
            bad++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready);
        end
        rst = 1'b0; in_valid = 1'b0;
        step();
    endtask

    task automatic test_full_pack();
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            in_valid = 1'b1; in_data = 4'(i);
            #1;
            total++;
            if (in_ready !== 1'b1) begin
                bad++; $display("FAIL full_in_ready lane=%0d got=%0b exp=1", i, in_ready);
            end
            step();
            if (i < 4) begin
                total++;
                if (out_valid !== 1'b0) begin
                    bad++; $display("FAIL full_early_valid lane=%0d got=%0b exp=0", i, out_valid);
                end
            end
        end
        in_valid = 1'b0;
        total++;
        if (out_valid !== 1'b1 || out_data !== 16'h4321 || out_cnt !== 3'd4) begin
            bad++;
            $display("FAIL full_word got v=%0b d=%h c=%0d exp v=1 d=4321 c=4", out_valid, out_data, out_cnt);
        end
        step();
        total++;
        if (out_valid !== 1'b0) begin
            bad++; $display("FAIL full_one_cycle got=%0b exp=0", out_valid);
        end
    endtask

    task automatic test_back_pressure();
        out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            in_valid = 1'b1; in_data = 4'(i);
            step();
        end
        total++;
        if (out_valid !== 1'b1 || out_data !== 16'h4321) begin
            bad++; $display("FAIL bp_held_word got v=%0b d=%h exp v=1 d=4321", out_valid, out_data);
        end
        for (int i = 5; i <= 7; i++) begin
            in_valid = 1'b1; in_data = 4'(i);
            #1;
            total++;
            if (in_ready !== 1'b1) begin
                bad++; $display("FAIL bp_accept lane=%0d got=%0b exp=1", i, in_ready);
            end
            step();
        end
        in_data = 4'h8;
        #1;
        total++;
        if (in_ready !== 1'b0) begin
            bad++; $display("FAIL bp_stall got=%0b exp=0", in_ready);
        end
        step();
        total++;
        if (in_ready !== 1'b0 || out_data !== 16'h4321 || out_cnt !== 3'd4) begin
            bad++;
            $display("FAIL bp_hold got rdy=%0b d=%h c=%0d exp rdy=0 d=4321 c=4", in_ready, out_data, out_cnt);
        end
        out_ready = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++; $display("FAIL bp_release got=%0b exp=1", in_ready);
        end
        step();
        in_valid = 1'b0;
        total++;
        if (out_valid !== 1'b1 || out_data !== 16'h8765 || out_cnt !== 3'd4) begin
            bad++;
            $display("FAIL bp_no_bubble got v=%0b d=%h c=%0d exp v=1 d=8765 c=4", out_valid, out_data, out_cnt);
        end
        step();
        total++;
        if (out_valid !== 1'b0) begin
            bad++; $display("FAIL bp_drain got=%0b exp=0", out_valid);
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = 4'hA;
        step();
        in_data = 4'h5;
        step();
        in_valid = 1'b0; flush = 1'b1;
        step();
        total++;
        if (out_valid !== 1'b1 || out_data !== 16'h005A || out_cnt !== 3'd2) begin
            bad++;
            $display("FAIL flush_word got v=%0b d=%h c=%0d exp v=1 d=005a c=2", out_valid, out_data, out_cnt);
        end
        step();
        total++;
        if (out_valid !== 1'b0) begin
            bad++; $display("FAIL flush_empty_noop got=%0b exp=0", out_valid);
        end
        flush = 1'b0;
    endtask

    task automatic test_flush_accept();
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = 4'hF;
        step();
        in_data = 4'h3; flush = 1'b1;
        step();
        in_valid = 1'b0; flush = 1'b0;
        total++;
        if (out_valid !== 1'b1 || out_data !== 16'h003F || out_cnt !== 3'd2) begin
            bad++;
            $display("FAIL flush_accept got v=%0b d=%h c=%0d exp v=1 d=003f c=2", out_valid, out_data, out_cnt);
        end
        step();
    endtask

    task automatic test_mid_reset();
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = 4'h9;
        step();
        in_data = 4'h7;
        step();
        in_valid = 1'b0; rst = 1'b1;
        step();
        rst = 1'b0;
        total++;
        if (out_valid !== 1'b0 || out_cnt !== 3'd0) begin
            bad++; $display("FAIL midrst_state got v=%0b c=%0d exp v=0 c=0", out_valid, out_cnt);
        end
        for (int i = 1; i <= 4; i++) begin
            in_valid = 1'b1; in_data = 4'(i);
            step();
        end
        in_valid = 1'b0;
        total++;
        if (out_valid !== 1'b1 || out_data !== 16'h4321 || out_cnt !== 3'd4) begin
            bad++;
            $display("FAIL midrst_word got v=%0b d=%h c=%0d exp v=1 d=4321 c=4", out_valid, out_data, out_cnt);
        end
`ifdef AND_PACK_PARITY_EN
        total++;
        if (out_parity !== 1'b1) begin
            bad++; $display("FAIL midrst_parity got=%0b exp=1", out_parity);
        end
`endif
        step();
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = 4'h0; flush = 1'b0; out_ready = 1'b0;
        test_reset();
        test_full_pack();
        test_back_pressure();
        test_flush();
        test_flush_accept();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
